// File: rtl/shift_arbiter_if.sv
// Handshake bundle between two shift requesters, the arbiter and the consumer.
// master: requesters + result consumer side; slave: the arbiter itself.
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_operand;
  logic [4:0]  req0_shiftamt;
  logic        req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_operand;
  logic [4:0]  req1_shiftamt;
  logic        req1_op;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_tag;

  modport master (
    output req0_valid, req0_operand,
    output req0_shiftamt, req0_op,
    input  req0_ready,
    output req1_valid, req1_operand,
    output req1_shiftamt, req1_op,
    input  req1_ready,
    input  res_valid, res_data, res_tag,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_operand,
    input  req0_shiftamt, req0_op,
    output req0_ready,
    input  req1_valid, req1_operand,
    input  req1_shiftamt, req1_op,
    output req1_ready,
    output res_valid, res_data, res_tag,
    input  res_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one SLL/SRA shifter between two requesters.
// Ports: clock, ctrl_reset_n (sync, active-low), bus (slave modport).
module shift_arbiter #(
  parameter bit FIRST_PRIORITY = 1'b0
) (
  input logic          clock,
  input logic          ctrl_reset_n,
  shift_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state;
  logic        last_grant;
  logic        res_tag_q;
  logic [31:0] res_data_q;

  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [31:0] sel_operand;
  logic [4:0]  sel_amt;
  logic        sel_op;
  logic [31:0] s1, s2, s4, s8, s16;

  assign can_accept = ctrl_reset_n &
                      ((state == IDLE) | bus.res_ready);

  // On contention the requester that did not win last time goes.
  assign grant1 = bus.req1_valid &
                  (~bus.req0_valid | ~last_grant);
  assign grant0 = bus.req0_valid & ~grant1;

  assign bus.req0_ready = can_accept & grant0;
  assign bus.req1_ready = can_accept & grant1;

  assign accept = bus.req0_ready | bus.req1_ready;

  assign sel_operand = grant1 ? bus.req1_operand
                              : bus.req0_operand;
  assign sel_amt     = grant1 ? bus.req1_shiftamt
                              : bus.req0_shiftamt;
  assign sel_op      = grant1 ? bus.req1_op : bus.req0_op;

  always_comb begin
    s1  = sel_operand;
    if (sel_amt[0])
      s1 = sel_op ? {sel_operand[31], sel_operand[31:1]}
                  : {sel_operand[30:0], 1'b0};
    s2  = s1;
    if (sel_amt[1])
      s2 = sel_op ? {{2{s1[31]}}, s1[31:2]}
                  : {s1[29:0], 2'b0};
    s4  = s2;
    if (sel_amt[2])
      s4 = sel_op ? {{4{s2[31]}}, s2[31:4]}
                  : {s2[27:0], 4'b0};
    s8  = s4;
    if (sel_amt[3])
      s8 = sel_op ? {{8{s4[31]}}, s4[31:8]}
                  : {s4[23:0], 8'b0};
    s16 = s8;
    if (sel_amt[4])
      s16 = sel_op ? {{16{s8[31]}}, s8[31:16]}
                   : {s8[15:0], 16'b0};
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state      <= IDLE;
      res_data_q <= '0;
      res_tag_q  <= 1'b0;
      last_grant <= ~FIRST_PRIORITY;
    end else if (accept) begin
      state      <= HOLD;
      res_data_q <= s16;
      res_tag_q  <= grant1;
      last_grant <= grant1;
    end else if (state == HOLD && bus.res_ready) begin
      state <= IDLE;
    end
  end

  assign bus.res_valid = (state == HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with hand-computed results.
// Drives the interface master side, checks with immediate assertions.
module tb_shift_arbiter;

  logic clock;
  logic ctrl_reset_n;
  int   checks;
  int   errors;

  shift_arbiter_if bus ();

  shift_arbiter #(.FIRST_PRIORITY(1'b0)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic v, input logic op,
                        input logic [31:0] d,
                        input logic [4:0] a);
    bus.req0_valid    = v;
    bus.req0_op       = op;
    bus.req0_operand  = d;
    bus.req0_shiftamt = a;
  endtask

  task automatic drive1(input logic v, input logic op,
                        input logic [31:0] d,
                        input logic [4:0] a);
    bus.req1_valid    = v;
    bus.req1_op       = op;
    bus.req1_operand  = d;
    bus.req1_shiftamt = a;
  endtask

  logic [31:0] exp_d [4];
  logic        exp_t [4];

  initial begin
    checks = 0;
    errors = 0;
    ctrl_reset_n  = 1'b0;
    bus.res_ready = 1'b1;
    drive0(1'b1, 1'b0, 32'h0000_00FF, 5'd3);
    drive1(1'b1, 1'b1, 32'hFFFF_0000, 5'd2);

    // reset held two cycles with both valid
    #1;
    chk("rst_rdy0_pre", {31'b0, bus.req0_ready}, 0);
    chk("rst_rdy1_pre", {31'b0, bus.req1_ready}, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_rdy0", {31'b0, bus.req0_ready}, 0);
      chk("rst_rdy1", {31'b0, bus.req1_ready}, 0);
      chk("rst_valid", {31'b0, bus.res_valid}, 0);
      chk("rst_data", bus.res_data, 32'h0);
      chk("rst_tag", {31'b0, bus.res_tag}, 0);
    end

    // req0 sra 0x80000000 >> 4
    ctrl_reset_n = 1'b1;
    drive1(1'b0, 1'b0, 32'h0, 5'd0);
    drive0(1'b1, 1'b1, 32'h8000_0000, 5'd4);
    #1;
    chk("sra_rdy0", {31'b0, bus.req0_ready}, 1);
    chk("sra_rdy1", {31'b0, bus.req1_ready}, 0);
    tick();
    chk("sra_valid", {31'b0, bus.res_valid}, 1);
    chk("sra_data", bus.res_data, 32'hF800_0000);
    chk("sra_tag", {31'b0, bus.res_tag}, 0);

    // req0 sra positive operand by 31
    drive0(1'b1, 1'b1, 32'h7FFF_FFFF, 5'd31);
    #1;
    chk("sra31_rdy0", {31'b0, bus.req0_ready}, 1);
    tick();
    chk("sra31_data", bus.res_data, 32'h0);
    chk("sra31_tag", {31'b0, bus.res_tag}, 0);

    // req1 sll edge cases
    drive0(1'b0, 1'b0, 32'h0, 5'd0);
    drive1(1'b1, 1'b0, 32'h0000_0001, 5'd31);
    #1;
    chk("sll31_rdy1", {31'b0, bus.req1_ready}, 1);
    tick();
    chk("sll31_data", bus.res_data, 32'h8000_0000);
    chk("sll31_tag", {31'b0, bus.res_tag}, 1);
    drive1(1'b1, 1'b0, 32'h1234_5678, 5'd0);
    tick();
    chk("sll0_data", bus.res_data, 32'h1234_5678);
    chk("sll0_tag", {31'b0, bus.res_tag}, 1);
    chk("sll0_valid", {31'b0, bus.res_valid}, 1);

    // contention: last grant was 1, so 0 wins first
    exp_d[0] = 32'h0000_0001; exp_t[0] = 1'b0;
    exp_d[1] = 32'hC000_0000; exp_t[1] = 1'b1;
    exp_d[2] = 32'h0000_0004; exp_t[2] = 1'b0;
    exp_d[3] = 32'hF000_0000; exp_t[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 32'h1, 5'(i));
      drive1(1'b1, 1'b1, 32'h8000_0000, 5'(i));
      #1;
      chk("cont_rdy0", {31'b0, bus.req0_ready},
          {31'b0, ~exp_t[i]});
      chk("cont_rdy1", {31'b0, bus.req1_ready},
          {31'b0, exp_t[i]});
      tick();
      chk("cont_tag", {31'b0, bus.res_tag},
          {31'b0, exp_t[i]});
      chk("cont_data", bus.res_data, exp_d[i]);
    end

    // backpressure: hold 0xF0000000/tag1 while req1 waits
    drive0(1'b0, 1'b0, 32'h0, 5'd0);
    drive1(1'b1, 1'b0, 32'h0000_00A5, 5'd4);
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy1", {31'b0, bus.req1_ready}, 0);
      chk("bp_rdy0", {31'b0, bus.req0_ready}, 0);
      tick();
      chk("bp_valid", {31'b0, bus.res_valid}, 1);
      chk("bp_data", bus.res_data, 32'hF000_0000);
      chk("bp_tag", {31'b0, bus.res_tag}, 1);
    end
    bus.res_ready = 1'b1;
    #1;
    chk("bp_rel_rdy1", {31'b0, bus.req1_ready}, 1);
    tick();
    chk("bp_rel_data", bus.res_data, 32'h0000_0A50);
    chk("bp_rel_tag", {31'b0, bus.res_tag}, 1);

    // reset while holding a result
    drive1(1'b0, 1'b0, 32'h0, 5'd0);
    bus.res_ready = 1'b0;
    ctrl_reset_n  = 1'b0;
    #1;
    chk("mrst_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 0);
    tick();
    chk("mrst_valid", {31'b0, bus.res_valid}, 0);
    chk("mrst_data", bus.res_data, 32'h0);

    // after release, contention goes to requester 0
    ctrl_reset_n  = 1'b1;
    bus.res_ready = 1'b1;
    drive0(1'b1, 1'b0, 32'h0000_0003, 5'd1);
    drive1(1'b1, 1'b0, 32'h0000_0005, 5'd1);
    #1;
    chk("prio_rdy0", {31'b0, bus.req0_ready}, 1);
    chk("prio_rdy1", {31'b0, bus.req1_ready}, 0);
    tick();
    chk("prio_tag", {31'b0, bus.res_tag}, 0);
    chk("prio_data", bus.res_data, 32'h0000_0006);

    // drained with no new request -> output empties
    drive0(1'b0, 1'b0, 32'h0, 5'd0);
    drive1(1'b0, 1'b0, 32'h0, 5'd0);
    tick();
    chk("drain_valid", {31'b0, bus.res_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit shift datapath between two requesters in the processor core. The datapath does a logical left shift (zero fill) and an arithmetic right shift (sign fill). The block arbitrates round-robin between requester 0 and requester 1 and accepts at most one operation per cycle. Each result is registered into a single-entry output stage with a valid/ready handshake and a tag naming the requester. It sits between the ALU issue logic and writeback, so both requesters use one shifter instance instead of each owning one.

## Interface
- FIRST_PRIORITY, default 0: the requester that wins the first contention after reset.
- clock  in  1  rising-edge clock.
- ctrl_reset_n  in  1  synchronous reset, active-low.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_operand  in  32  value to shift.
- req0_shiftamt  in  5  shift amount, 0–31.
- req0_op  in  1  0 = shift left logical, 1 = shift right arithmetic.
- req1_valid, req1_ready, req1_operand, req1_shiftamt, req1_op: same widths and meaning as requester 0.
- res_valid  out  1  the output register holds a result.
- res_ready  in  1  the consumer takes the result this cycle.
- res_data  out  32  registered shift result.
- res_tag  out  1  requester id of the result: 0 or 1.

## Operation
- Output FSM has two states:
  - IDLE: res_valid=0.
  - HOLD: res_valid=1.
- can_accept = (state==IDLE) | (state==HOLD & res_ready).
- Arbitration uses the register last_grant:
  - Only one reqN_valid high: that requester is granted.
  - Both high: the requester ≠ last_grant is granted.
  - last_grant resets to ~FIRST_PRIORITY.
- reqN_ready = can_accept & grantN. At most one ready is high in any cycle.
- Ready depends combinationally on valid and res_ready. Requesters must not derive valid from ready.
- Accept means reqN_valid & reqN_ready. On accept, at the clock edge:
  - res_data <= shift(operandN, shiftamtN, opN).
  - res_tag <= N.
  - last_grant <= N.
  - state <= HOLD.
- State transitions:
  - IDLE & accept -> HOLD.
  - HOLD & res_ready & accept -> HOLD, with the new result loaded.
  - HOLD & res_ready & no accept -> IDLE.
  - HOLD & !res_ready -> HOLD.
- While in HOLD with res_ready=0, res_data and res_tag stay stable and both readies are 0.
- last_grant changes only on accept. Idle cycles do not disturb fairness.
- Shift arithmetic: five cascaded conditional stages (1, 2, 4, 8, 16), one per shiftamt bit.
  - Left shift: fill vacated bits with 0.
  - Right shift: fill vacated bits with operand[31].
  - shiftamt=0: pass the operand through unchanged.
  - The result is always 32 bits; there is no overflow flag.
- Operand inputs are sampled only in the accept cycle. Values outside the accept cycle are don't-care.
- Reset (ctrl_reset_n=0 at an edge):
  - state <= IDLE, res_valid <= 0, res_data <= 0, res_tag <= 0, last_grant <= ~FIRST_PRIORITY.
  - Any held result is discarded.
  - Both readies are forced to 0 while ctrl_reset_n=0.

## Timing
- Latency is 1 cycle: accept at edge N -> res_valid=1 with the result after edge N.
- Throughput is 1 operation per cycle while res_ready is held at 1 and a requester is valid.
- Both requesters continuously valid gives strictly alternating grants.
- Output stage holds one entry. Full means HOLD & !res_ready, which stalls all requesters.
- The first accept after release of reset is in the first cycle with ctrl_reset_n=1.
- Reset values of outputs:
  - res_valid=0, res_data=0x00000000, res_tag=0.
  - req0_ready=0 and req1_ready=0 during reset. After reset they follow the arbitration rule.

## Test plan
- Reset:
  - Stimulus: hold ctrl_reset_n=0 for 2 cycles with both valid=1.
  - Response: both readies 0 throughout; res_valid=0, res_data=0 after the first edge.
- Requester 0, arithmetic right shift:
  - Stimulus: req0 sra, 0x80000000, shiftamt 4.
  - Response: next cycle res_valid=1, res_data=0xF8000000, res_tag=0.
- Requester 0, sign fill with positive operand:
  - Stimulus: req0 sra, 0x7FFFFFFF, shiftamt 31.
  - Response: res_data=0x00000000.
- Requester 1, left shift edge cases:
  - Stimulus: req1 sll, 0x00000001, shiftamt 31.
  - Response: res_data=0x80000000, res_tag=1.
  - Stimulus: then sll, 0x12345678, shiftamt 0.
  - Response: res_data=0x12345678.
- Contention:
  - Stimulus: both valid for 4 cycles with res_ready=1 and FIRST_PRIORITY=0.
  - Response: accepted tags are 0,1,0,1 on consecutive cycles; the last result comes one cycle after the last accept.
- Backpressure:
  - Stimulus: result held with res_ready=0 for 3 cycles while req1 is valid.
  - Response: req1_ready=0, and res_data/res_tag stay stable.
  - Stimulus: raise res_ready.
  - Response: req1 is accepted in that same cycle and the new result appears the next cycle.
- Reset mid-operation:
  - Stimulus: assert ctrl_reset_n=0 while in HOLD.
  - Response: res_valid=0 the next cycle and the held result is lost.
  - Stimulus: after release, contention.
  - Response: requester FIRST_PRIORITY wins.
